dec_to_octal_seq: RTL and testbench

//   Multi-cycle converter controller: converts an unsigned binary ("decimal") value to its octal form,
//   one octal digit per clock. Result is decimal-coded octal, e.g. 127 -> 177, so it reads correctly

---
 rtl/dec_oct_pkg.sv | 19 +
 rtl/dec_oct_step.sv | 33 +++
 rtl/dec_to_octal_seq.sv | 116 +++++++++++
 tb/tb_dec_to_octal_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dec_oct_pkg.sv
// Shared types and helpers for the binary-to-octal sequential converter.
// The state encoding and digit geometry live here so that the shell and the step agree.
package dec_oct_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Bits per octal digit
    localparam int DIG_W = 3;

    // Number of octal digit slots needed for an in_w-bit unsigned value
    function automatic int maxd(input int in_w);
        return (in_w + 2) / 3;
    endfunction

endpackage

// File: rtl/dec_oct_step.sv
// One combinational octal-digit step: peel the low three bits off the remainder,
// weight them by the current power of ten and fold them into the accumulator.
// Multiplies are avoided: digit*pow is a sum of shifted pows, and x10 is (<<3)+(<<1).
module dec_oct_step
    import dec_oct_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20
) (
    input  logic [IN_W-1:0]  rem,
    input  logic [OUT_W-1:0] acc,
    input  logic [OUT_W-1:0] pow,
    output logic [IN_W-1:0]  rem_n,
    output logic [OUT_W-1:0] acc_n,
    output logic [OUT_W-1:0] pow_n,
    output logic             last
);

    logic [OUT_W-1:0] prod;

    // Digit weight as shift-add over the three digit bits, then advance all step state
    always_comb begin
        prod = '0;
        if (rem[0]) prod = prod + pow;
        if (rem[1]) prod = prod + (pow << 1);
        if (rem[2]) prod = prod + (pow << 2);
        acc_n = acc + prod;
        rem_n = rem >> DIG_W;
        pow_n = (pow << 3) + (pow << 1);
        last  = (rem_n == '0);
    end

endmodule

// File: rtl/dec_to_octal_seq.sv
// Multi-cycle binary to decimal-coded-octal converter (127 -> 177), one digit per clock,
// with a start/busy/done handshake. octal_out holds the last result until the next one lands.
// Optional build macro: DEC2OCT_NDIGITS_EN adds the ndigits output (digit count of the result).
module dec_to_octal_seq
    import dec_oct_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  dec_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] octal_out
`ifdef DEC2OCT_NDIGITS_EN
    ,
    output logic [2:0]       ndigits
`endif
);

    // Digit slot limit; stops the walk even if the remainder has not yet drained
    localparam logic [2:0] MAXD_C = 3'(maxd(IN_W));

    state_t           state;
    logic [IN_W-1:0]  rem;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] pow;
    logic [2:0]       cnt;

    logic [IN_W-1:0]  rem_n;
    logic [OUT_W-1:0] acc_n;
    logic [OUT_W-1:0] pow_n;
    logic             last;
    logic [2:0]       cnt_n;

    assign cnt_n = cnt + 3'd1;

    dec_oct_step #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_step (
        .rem   (rem),
        .acc   (acc),
        .pow   (pow),
        .rem_n (rem_n),
        .acc_n (acc_n),
        .pow_n (pow_n),
        .last  (last)
    );

    // Handshake FSM and conversion registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            octal_out <= '0;
            rem       <= '0;
            acc       <= '0;
            pow       <= '0;
            cnt       <= '0;
`ifdef DEC2OCT_NDIGITS_EN
            ndigits   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= dec_in;
                        acc   <= '0;
                        pow   <= OUT_W'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    rem <= rem_n;
                    acc <= acc_n;
                    pow <= pow_n;
                    cnt <= cnt_n;
                    if (last || (cnt_n == MAXD_C)) begin
                        octal_out <= acc_n;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
`ifdef DEC2OCT_NDIGITS_EN
                        ndigits   <= cnt_n;
`endif
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem   <= dec_in;
                        acc   <= '0;
                        pow   <= OUT_W'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_octal_seq.sv
// Directed bench for dec_to_octal_seq: hand-computed octal results, latency, busy width,
// single-cycle done, ignored start while busy, back-to-back start, and mid-conversion reset.
// Works with or without DEC2OCT_NDIGITS_EN defined.
module tb_dec_to_octal_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dec_in;
    logic        busy;
    logic        done;
    logic [19:0] octal_out;
`ifdef DEC2OCT_NDIGITS_EN
    logic [2:0]  ndigits;
`endif

    int checks;
    int errors;

    dec_to_octal_seq #(
        .IN_W  (16),
        .OUT_W (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dec_in    (dec_in),
        .busy      (busy),
        .done      (done),
        .octal_out (octal_out)
`ifdef DEC2OCT_NDIGITS_EN
        ,
        .ndigits   (ndigits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for done with a bound; returns cycles since the accept edge and busy-high cycles seen
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full request: accept, wait for result, check value, timing and the done pulse width
    task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] exp,
                           input int nd);
        int lat;
        int bc;
        @(negedge clk);
        dec_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        wait_done(lat, bc);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(nd));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(nd));
        check({tag, "_octal"}, 32'(octal_out), 32'(exp));
`ifdef DEC2OCT_NDIGITS_EN
        check({tag, "_ndigits"}, 32'(ndigits), 32'(nd));
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_octal_hold"}, 32'(octal_out), 32'(exp));
    endtask

    initial begin
        int lat;
        int bc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        dec_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_octal", 32'(octal_out), 32'd0);
`ifdef DEC2OCT_NDIGITS_EN
        check("rst_ndigits", 32'(ndigits), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic conversions and boundaries
        convert("c127",   16'd127,   20'd177,    3);
        convert("c1473",  16'd1473,  20'd2701,   4);
        convert("c261",   16'd261,   20'd405,    3);
        convert("c0",     16'd0,     20'd0,      1);
        convert("c65535", 16'd65535, 20'd177777, 6);

        // start held during CONVERT is ignored, then back-to-back accept from DONE
        @(negedge clk);
        dec_in = 16'd127;
        start  = 1'b1;
        @(posedge clk); #1;
        dec_in = 16'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("ign_done", 32'(done), 32'd1);
        check("ign_octal", 32'(octal_out), 32'd177);
        dec_in = 16'd8;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_octal_held", 32'(octal_out), 32'd177);
        wait_done(lat, bc);
        check("b2b_latency", 32'(lat), 32'd2);
        check("b2b_octal", 32'(octal_out), 32'd10);
`ifdef DEC2OCT_NDIGITS_EN
        check("b2b_ndigits", 32'(ndigits), 32'd2);
`endif
        @(posedge clk); #1;

        // Reset in the middle of a 1399 conversion
        @(negedge clk);
        dec_in = 16'd1399;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_octal", 32'(octal_out), 32'd0);
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) bc++;
        end
        check("abort_quiet", 32'(bc), 32'd0);
        convert("c1399", 16'd1399, 20'd2567, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
